// File: rtl/mult_pkg.sv
// mult_pkg: shared types for the iterative RV32M multiplier.
//   mult_op_e    - MUL / MULH / MULHSU / MULHU encodings (match the op port)
//   mult_state_e - control FSM states
//   shift_dir_e  - shift direction for mult_shift_reg
//   op_signed()  - per-operand signedness for a given op (idx 0 = rs1, 1 = rs2)
package mult_pkg;

    typedef enum logic [1:0] {
        OpMul    = 2'd0,
        OpMulh   = 2'd1,
        OpMulhsu = 2'd2,
        OpMulhu  = 2'd3
    } mult_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StDone
    } mult_state_e;

    typedef enum logic {
        ShiftLeft  = 1'b0,
        ShiftRight = 1'b1
    } shift_dir_e;

    // MUL takes both operands as unsigned: the low half is the same either way.
    function automatic logic op_signed(input mult_op_e op, input logic idx);
        if (idx == 1'b0) begin
            return (op == OpMulh) || (op == OpMulhsu);
        end
        return op == OpMulh;
    endfunction

endpackage

// File: rtl/mult_shift_reg.sv
// mult_shift_reg: W-bit shift register with synchronous reset, parallel load and
// single-bit shift. Priority: Reset > load_i > shift_i.
// Ports:
//   Clk, Reset   - clock, synchronous active-high reset (clears to 0)
//   load_i       - load load_val_i
//   load_val_i   - parallel load value
//   shift_i      - shift by one in direction DIR
//   serial_i     - bit shifted in (LSB for ShiftLeft, MSB for ShiftRight)
//   serial_o     - bit about to be shifted out (MSB for ShiftLeft, LSB for ShiftRight)
//   q_o          - register contents
module mult_shift_reg
    import mult_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter shift_dir_e  DIR = ShiftLeft
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         serial_i,
    output logic         serial_o,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (shift_i) begin
            if (DIR == ShiftRight) begin
                q_d = {serial_i, q_q[W-1:1]};
            end else begin
                q_d = {q_q[W-2:0], serial_i};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign serial_o = (DIR == ShiftRight) ? q_q[0] : q_q[W-1];
    assign q_o      = q_q;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, one
// multiplier bit per cycle. Operands are reduced to magnitudes, multiplied
// unsigned, and the 2*WIDTH-bit product is negated at the end when exactly one
// operand was negative.
// Ports:
//   Clk, Reset - clock, synchronous active-high reset
//   start_i    - launch request, accepted only while ready_o is high
//   kill_i     - flush; returns to idle at the next edge, no done, result kept
//   op_i       - 0 MUL (low half), 1 MULH, 2 MULHSU, 3 MULHU (high half)
//   rs1_i      - multiplicand
//   rs2_i      - multiplier
//   ready_o    - idle, can accept start_i
//   done_o     - one-cycle pulse, result_o valid
//   result_o   - selected product half, held until the next completed op
// Build option: define SEQ_MULT_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (results unchanged, latency shorter).
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned PW = 2 * WIDTH;

    mult_state_e      state_q, state_d;
    mult_op_e         op_q, op_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept, shift_en, calc_last;
    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [PW-1:0]    mcand_q, acc_fix;
    logic [WIDTH-1:0] mplr_q;
    logic             unused_mcand_msb, unused_mplr_lsb;

    assign accept   = (state_q == StIdle) && start_i && !kill_i;
    assign shift_en = (state_q == StCalc) && !kill_i;

    assign sign1 = op_signed(mult_op_e'(op_i), 1'b0) && rs1_i[WIDTH-1];
    assign sign2 = op_signed(mult_op_e'(op_i), 1'b1) && rs2_i[WIDTH-1];
    // Most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag1  = sign1 ? (~rs1_i + WIDTH'(1)) : rs1_i;
    assign mag2  = sign2 ? (~rs2_i + WIDTH'(1)) : rs2_i;

    mult_shift_reg #(
        .W   (PW),
        .DIR (ShiftLeft)
    ) u_mcand (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (accept),
        .load_val_i ({{WIDTH{1'b0}}, mag1}),
        .shift_i    (shift_en),
        .serial_i   (1'b0),
        .serial_o   (unused_mcand_msb),
        .q_o        (mcand_q)
    );

    mult_shift_reg #(
        .W   (WIDTH),
        .DIR (ShiftRight)
    ) u_mplr (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (accept),
        .load_val_i (mag2),
        .shift_i    (shift_en),
        .serial_i   (1'b0),
        .serial_o   (unused_mplr_lsb),
        .q_o        (mplr_q)
    );

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Next multiplier value is zero: no further partial products can be added.
    assign calc_last = (cnt_q == CNT_W'(WIDTH - 1)) || (mplr_q[WIDTH-1:1] == '0);
`else
    assign calc_last = (cnt_q == CNT_W'(WIDTH - 1));
    logic unused_mplr_hi;
    assign unused_mplr_hi = ^mplr_q[WIDTH-1:1];
`endif

    assign acc_fix = neg_q ? (~acc_q + PW'(1)) : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (kill_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_d    = mult_op_e'(op_i);
                        neg_d   = sign1 ^ sign2;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    if (mplr_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (calc_last) begin
                        state_d = StFixup;
                    end
                end
                StFixup: begin
                    acc_d    = acc_fix;
                    result_d = (op_q == OpMul) ? acc_fix[WIDTH-1:0] : acc_fix[PW-1:WIDTH];
                    state_d  = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and small randomised checks of seq_multiplier
// (WIDTH=32) against hand-computed values and a 64-bit arithmetic reference.
module tb_seq_multiplier;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    seq_multiplier #(
        .WIDTH (32)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start_i  (start),
        .kill_i   (kill),
        .op_i     (op),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .ready_o  (ready),
        .done_o   (done),
        .result_o (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] a64, b64, p;
        a64 = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        b64 = (o == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = a64 * b64;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          n;
        m = (o == 2'd1 && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        return 2 + n;
`else
        return 34;
`endif
    endfunction

    // Called one step after a posedge with the DUT idle; returns in the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit got);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
        got = done;
        res = result;
    endtask

    task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int          lat;
        logic [31:0] res;
        bit          got;
        do_op(o, a, b, lat, res, got);
        check({tag, "_done"}, 64'(got), 64'd1);
        check({tag, "_res"}, 64'(res), 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, b)));
        @(posedge Clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_ready"}, 64'(ready), 64'd1);
    endtask

    typedef struct packed {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t        vecs[11];
    bit          seen;
    int          lat;
    logic [31:0] res;
    bit          got;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        vecs = '{
            '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{2'd0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000},
            '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF},
            '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1},
            '{2'd3, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002},
            '{2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF},
            '{2'd2, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001},
            '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
        };

        Reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'd0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);

        // start together with kill is dropped
        op = 2'd0; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1; kill = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; kill = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (done || !ready) seen = 1'b1;
            @(posedge Clk); #1;
        end
        check("killstart_nodone", 64'(seen), 64'd0);
        check("killstart_result", 64'(result), 64'd0);

        // directed vectors, each launched on the first idle cycle after the previous done
        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].r);
        end

        // kill 10 cycles into CALC
        run_vec("pre_kill", 2'd0, 32'd7, 32'd3, 32'd21);
        op = 2'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check("calc_busy", 64'(ready), 64'd0);
        kill = 1'b1;
        @(posedge Clk); #1;
        kill = 1'b0;
        check("kill_ready", 64'(ready), 64'd1);
        check("kill_nodone", 64'(done), 64'd0);
        check("kill_result", 64'(result), 64'd21);
        run_vec("post_kill", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

        // start pulse during CALC is ignored and not queued
        op = 2'd0; rs1 = 32'h10; rs2 = 32'h10; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; lat = 1;
        @(posedge Clk); #1;
        lat++;
        op = 2'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; lat++;
        while (!done && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("ignore_done", 64'(done), 64'd1);
        check("ignore_res", 64'(result), 64'h100);
        check("ignore_lat", 64'(lat), 64'(exp_lat(2'd0, 32'h10)));
        seen = 1'b0;
        @(posedge Clk); #1;
        repeat (40) begin
            if (done || !ready) seen = 1'b1;
            @(posedge Clk); #1;
        end
        check("ignore_noqueue", 64'(seen), 64'd0);

        // kill during DONE leaves the visible done alone
        do_op(2'd1, 32'hFFFF_FFFE, 32'h0000_0003, lat, res, got);
        check("dkill_got", 64'(got), 64'd1);
        kill = 1'b1;
        #1;
        check("dkill_done_vis", 64'(done), 64'd1);
        check("dkill_res", 64'(result), 64'hFFFF_FFFF);
        @(posedge Clk); #1;
        kill = 1'b0;
        check("dkill_ready", 64'(ready), 64'd1);

        // reset mid-operation
        op = 2'd3; rs1 = 32'h1234; rs2 = 32'h5678; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_result", 64'(result), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            @(posedge Clk); #1;
        end
        check("midrst_nodone", 64'(seen), 64'd0);

        // randomised operands against the 64-bit reference
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'(i) : $urandom;
            run_vec($sformatf("rnd%0d", i), ro, ra, rb, ref_mul(ro, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
